multicycle_controller: RTL



---
 rtl/multicycle_controller.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RV32I datapath.
// Moore state machine with registered control outputs, an ALU decoder for
// R/I-type ops and a combinational immediate-type decoder.
// Optional feature macro: CTRL_FETCH_WAIT_EN inserts FETCH_WAIT_CYCLES
// wait cycles (1..3) in front of every FETCH to cover block-RAM read latency.
module multicycle_controller #(
    parameter int FETCH_WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_MEMADR     = 4'd2,
        S_MEMREAD    = 4'd3,
        S_MEMWB      = 4'd4,
        S_MEMWRITE   = 4'd5,
        S_EXECR      = 4'd6,
        S_EXECI      = 4'd7,
        S_ALUWB      = 4'd8,
        S_BRANCH     = 4'd9,
        S_JAL        = 4'd10,
        S_JALR       = 4'd11,
        S_JALRWB     = 4'd12,
        S_UPPER      = 4'd13,
        S_FETCH_WAIT = 4'd14,
        S_ILLEGAL    = 4'd15
    } state_t;

    // Control bundle held in flops; 'branch' marks the BRANCH state so the
    // Zero-dependent PC enable can be formed against the live ALU flag.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       branch;
    } ctrl_t;

    // Every path that would return to FETCH goes through FETCH_WAIT when
    // the wait feature is built in; otherwise FETCH_WAIT is unreachable.
`ifdef CTRL_FETCH_WAIT_EN
    localparam state_t FETCH_ENTRY = S_FETCH_WAIT;
`else
    localparam state_t FETCH_ENTRY = S_FETCH;
`endif

    localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT_CYCLES - 1);

    // Unsupported funct3 encodings for the ALU ops (shifts, sltu).
    function automatic logic alu_f3_bad(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b011) || (f3 == 3'b101);
    endfunction

    // ALU operation for R-type (op5=1) and I-type (op5=0) instructions.
    function automatic logic [2:0] alu_decode(input logic op5, input logic [2:0] f3,
                                              input logic f7);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (op5 && f7) ? 3'b001 : 3'b000;
            3'b010:  ctl = 3'b101;
            3'b100:  ctl = 3'b100;
            3'b110:  ctl = 3'b011;
            3'b111:  ctl = 3'b010;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    // Control values to present while sitting in state s.
    function automatic ctrl_t ctrl_for(input state_t s, input logic op5,
                                       input logic [2:0] f3, input logic f7);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = alu_decode(op5, f3, f7);
            end
            S_EXECI: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b01;
                c.alu_control = alu_decode(op5, f3, f7);
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = 3'b001;
                c.branch      = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
            end
            S_JALRWB: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.reg_write  = 1'b1;
            end
            S_UPPER: begin
                c.alu_src_a = op5 ? 2'b11 : 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_FETCH_WAIT: c = '0;
            S_ILLEGAL:    c = '0;
            default:      c = '0;
        endcase
        return c;
    endfunction

    localparam ctrl_t CTRL_RESET = ctrl_for(FETCH_ENTRY, 1'b0, 3'b000, 1'b0);

    state_t     state_q, state_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl_q, ctrl_d;

    // Next-state, fetch-wait counter and sticky illegal flag.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111, 7'b0010111: state_d = S_UPPER;
                    default: begin
                        state_d   = S_ILLEGAL;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = FETCH_ENTRY;
            S_MEMWRITE: state_d = FETCH_ENTRY;
            S_EXECR, S_EXECI: begin
                state_d = S_ALUWB;
                if (alu_f3_bad(funct3)) begin
                    illegal_d = 1'b1;
                end else begin
                    illegal_d = illegal_q;
                end
            end
            S_ALUWB:  state_d = FETCH_ENTRY;
            S_BRANCH: state_d = FETCH_ENTRY;
            S_JAL:    state_d = S_ALUWB;
            S_JALR:   state_d = S_JALRWB;
            S_JALRWB: state_d = FETCH_ENTRY;
            S_UPPER:  state_d = S_ALUWB;
            S_FETCH_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_FETCH;
                    wait_cnt_d = 2'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_ILLEGAL: begin
                state_d   = S_ILLEGAL;
                illegal_d = 1'b1;
            end
            default: state_d = FETCH_ENTRY;
        endcase
    end

    // Controls for the upcoming state, registered so they change only at the edge.
    always_comb begin
        ctrl_d = ctrl_for(state_d, op[5], funct3, funct7b5);
    end

    // State, counter, illegal flag and control registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= FETCH_ENTRY;
            wait_cnt_q <= 2'd0;
            illegal_q  <= 1'b0;
            ctrl_q     <= CTRL_RESET;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        case (op)
            7'b0100011:             ImmSrc = 3'b001;
            7'b1100011:             ImmSrc = 3'b010;
            7'b1101111:             ImmSrc = 3'b011;
            7'b0110111, 7'b0010111: ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

    // Enables are gated by resetn so none can pulse once reset is asserted,
    // even before the asynchronous clear has propagated through the flops.
    assign PCWrite    = resetn & (ctrl_q.pc_write | (ctrl_q.branch & (Zero ^ funct3[0])));
    assign MemWrite   = resetn & ctrl_q.mem_write;
    assign IRWrite    = resetn & ctrl_q.ir_write;
    assign RegWrite   = resetn & ctrl_q.reg_write;
    assign AdrSrc     = ctrl_q.adr_src;
    assign ResultSrc  = ctrl_q.result_src;
    assign ALUControl = ctrl_q.alu_control;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign illegal    = illegal_q;
    assign state      = state_q;

endmodule
